// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and state encoding for the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Payload bits per frame and rxclk_en ticks per bit period
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // Receiver state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync2ff
// Description : Two-flop synchronizer for an asynchronous single-bit input,
//               with a selectable reset value for the idle level of the pin.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta_q;
    logic r_sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q <= RESET_VAL;
            r_sync_q <= RESET_VAL;
        end else begin
            r_meta_q <= i_async;
            r_sync_q <= r_meta_q;
        end
    end

    assign o_sync = r_sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver driven by a 16x oversampling enable.
//               Samples each bit at its centre, delivers bytes through a
//               ready/clear handshake and reports framing and overrun errors.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int MID_SAMPLE = OVERSAMPLE / 2 - 1
) (
    input  logic                 clock50,
    input  logic                 reset,
    input  logic                 rxclk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 frame_err,
    output logic                 overrun
);

    import uart_pkg::*;

    localparam int                SAMP_W      = $clog2(OVERSAMPLE);
    localparam int                BIT_W       = $clog2(DATA_BITS);
    localparam logic [SAMP_W-1:0] C_MID       = SAMP_W'(MID_SAMPLE);
    localparam logic [SAMP_W-1:0] C_LAST_SAMP = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  C_LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 w_rx_s;

    uart_state_t          r_state_q,     w_state_d;
    logic [SAMP_W-1:0]    r_sample_q,    w_sample_d;
    logic [BIT_W-1:0]     r_bitpos_q,    w_bitpos_d;
    logic [DATA_BITS-1:0] r_scratch_q,   w_scratch_d;
    logic [DATA_BITS-1:0] r_data_q,      w_data_d;
    logic                 r_ready_q,     w_ready_d;
    logic                 r_frame_err_q, w_frame_err_d;
    logic                 r_overrun_q,   w_overrun_d;

    logic                 w_frame_good;
    logic                 w_frame_bad;

    sync2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clock50),
        .rst     (reset),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    // Frame sequencing: start detection, centre sampling, stop bit check
    always_comb begin
        w_state_d    = r_state_q;
        w_sample_d   = r_sample_q;
        w_bitpos_d   = r_bitpos_q;
        w_scratch_d  = r_scratch_q;
        w_frame_good = 1'b0;
        w_frame_bad  = 1'b0;
        if (rxclk_en) begin
            case (r_state_q)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_d  = START;
                        w_sample_d = SAMP_W'(1);
                    end else begin
                        w_sample_d = '0;
                    end
                end
                START: begin
                    if (w_rx_s) begin
                        // Line went high before mid-start: treat as noise
                        w_state_d  = IDLE;
                        w_sample_d = '0;
                    end else if (r_sample_q == C_MID) begin
                        w_state_d  = DATA;
                        w_sample_d = '0;
                        w_bitpos_d = '0;
                    end else begin
                        w_sample_d = r_sample_q + 1'b1;
                    end
                end
                DATA: begin
                    if (r_sample_q == C_LAST_SAMP) begin
                        w_sample_d              = '0;
                        w_scratch_d[r_bitpos_q] = w_rx_s;
                        if (r_bitpos_q == C_LAST_BIT) begin
                            w_state_d = STOP;
                        end else begin
                            w_bitpos_d = r_bitpos_q + 1'b1;
                        end
                    end else begin
                        w_sample_d = r_sample_q + 1'b1;
                    end
                end
                STOP: begin
                    if (r_sample_q == C_LAST_SAMP) begin
                        // Leave at mid-stop so a following start edge is not missed
                        w_sample_d   = '0;
                        w_state_d    = IDLE;
                        w_frame_good = w_rx_s;
                        w_frame_bad  = !w_rx_s;
                    end else begin
                        w_sample_d = r_sample_q + 1'b1;
                    end
                end
                default: begin
                    w_state_d  = IDLE;
                    w_sample_d = '0;
                end
            endcase
        end
    end

    // Consumer handshake and status; a completing byte outranks a same-cycle clear
    always_comb begin
        w_data_d      = r_data_q;
        w_ready_d     = r_ready_q;
        w_frame_err_d = r_frame_err_q;
        w_overrun_d   = r_overrun_q;
        if (rdy_clr) begin
            w_ready_d   = 1'b0;
            w_overrun_d = 1'b0;
        end
        if (w_frame_good) begin
            w_data_d      = r_scratch_q;
            w_ready_d     = 1'b1;
            w_frame_err_d = 1'b0;
            if (r_ready_q && !rdy_clr) begin
                w_overrun_d = 1'b1;
            end
        end
        if (w_frame_bad) begin
            w_frame_err_d = 1'b1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock50) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_sample_q    <= '0;
            r_bitpos_q    <= '0;
            r_scratch_q   <= '0;
            r_data_q      <= '0;
            r_ready_q     <= 1'b0;
            r_frame_err_q <= 1'b0;
            r_overrun_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_sample_q    <= w_sample_d;
            r_bitpos_q    <= w_bitpos_d;
            r_scratch_q   <= w_scratch_d;
            r_data_q      <= w_data_d;
            r_ready_q     <= w_ready_d;
            r_frame_err_q <= w_frame_err_d;
            r_overrun_q   <= w_overrun_d;
        end
    end

    assign data      = r_data_q;
    assign ready     = r_ready_q;
    assign frame_err = r_frame_err_q;
    assign overrun   = r_overrun_q;

endmodule
`default_nettype wire
